// File: rtl/cache_replace_data_if.sv
// Word-wide memory bus between the line-replacement engine and memory.
// waitRequest stalls a request; readDataValid strobes in-order read data.
interface cache_replace_data_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writeData;
    logic        waitRequest;
    logic [31:0] readData;
    logic        readDataValid;

    modport master (
        output address, read, write, writeData,
        input  waitRequest, readData, readDataValid
    );

    modport slave (
        input  address, read, write, writeData,
        output waitRequest, readData, readDataValid
    );
endinterface

// File: rtl/cache_replace_data.sv
// Line-replacement engine: optional dirty write-back, then line refill.
// Build option: CACHE_REPLACE_CRITICAL_WORD_FIRST_EN (critical-word-first refill).
module cache_replace_data #(
    parameter int ADDR_WIDTH      = 8,
    parameter int LINE_WORDS_LOG2 = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   start_dirty,
    input  logic [1:0]                             start_ch,
    input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0]  start_index,
    input  logic [31:0]                            start_wbAddr,
    input  logic [31:0]                            start_refillAddr,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   sel,
    output logic [ADDR_WIDTH-1:0]                  ri_readAddress,
    output logic [1:0]                             ri_rwChannel,
    input  logic [31:0]                            ri_readData,
    output logic [ADDR_WIDTH-1:0]                  ri_writeAddress,
    output logic [3:0]                             ri_writeByteEnable,
    output logic                                   ri_writeEnable,
    output logic [31:0]                            ri_writeData,
    cache_replace_data_if.master                   mem,
    output logic                                   fwd_valid,
    output logic [31:0]                            fwd_data
);
    localparam int LW = LINE_WORDS_LOG2;
    localparam int IW = ADDR_WIDTH - LINE_WORDS_LOG2;

    typedef logic [LW-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE, WB_RD, WB_WR, RF_REQ, RF_WAIT, DONE
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    ch_q;
    logic [IW-1:0] index_q;
    logic [31:0]   wb_addr_q;
    logic [31:0]   rf_base_q;
    cnt_t          wb_cnt, req_cnt, rsp_cnt;
    cnt_t          crit, req_off, rsp_off;
    logic          launch, wb_acc, rf_acc, rsp_fire;

    assign launch   = (state == IDLE) && start;
    assign wb_acc   = (state == WB_WR) && !mem.waitRequest;
    assign rf_acc   = (state == RF_REQ) && !mem.waitRequest;
    assign rsp_fire = mem.readDataValid &&
                      ((state == RF_REQ) || (state == RF_WAIT));

    // Request and response counters run from 0; the line offset adds crit.
    assign req_off = req_cnt + crit;
    assign rsp_off = rsp_cnt + crit;

`ifdef CACHE_REPLACE_CRITICAL_WORD_FIRST_EN
    cnt_t crit_q;
    logic unused_addr;

    // Capture the word offset of the refill address as the first word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crit_q <= '0;
        else if (launch)
            crit_q <= start_refillAddr[LW+1:2];
    end

    assign crit        = crit_q;
    assign unused_addr = ^start_refillAddr[1:0];
    assign fwd_valid   = rsp_fire && (rsp_cnt == '0);
    assign fwd_data    = fwd_valid ? mem.readData : 32'h0;
`else
    logic unused_addr;

    assign crit        = '0;
    assign unused_addr = ^start_refillAddr[LW+1:0];
    assign fwd_valid   = 1'b0;
    assign fwd_data    = 32'h0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Latch the request; later start pulses are ignored until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            index_q   <= '0;
            wb_addr_q <= '0;
            rf_base_q <= '0;
        end else if (launch) begin
            ch_q      <= start_ch;
            index_q   <= start_index;
            wb_addr_q <= start_wbAddr;
            rf_base_q <= {start_refillAddr[31:LW+2], {(LW+2){1'b0}}};
        end
    end

    // Word counters; each wraps to 0 after the last word of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt  <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else if (launch) begin
            wb_cnt  <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            if (wb_acc)
                wb_cnt <= wb_cnt + 1'b1;
            if (rf_acc)
                req_cnt <= req_cnt + 1'b1;
            if (rsp_fire)
                rsp_cnt <= rsp_cnt + 1'b1;
        end
    end

    // Next state and all port outputs; outputs idle at 0.
    always_comb begin
        state_nx           = state;
        busy               = 1'b0;
        sel                = 1'b0;
        done               = 1'b0;
        ri_rwChannel       = 2'b00;
        ri_readAddress     = '0;
        ri_writeAddress    = '0;
        ri_writeByteEnable = 4'h0;
        ri_writeEnable     = 1'b0;
        ri_writeData       = 32'h0;
        mem.address        = 32'h0;
        mem.read           = 1'b0;
        mem.write          = 1'b0;
        mem.writeData      = 32'h0;

        if (state != IDLE) begin
            busy         = 1'b1;
            sel          = 1'b1;
            ri_rwChannel = ch_q;
        end

        // A response lands in the array the cycle it arrives.
        if (rsp_fire) begin
            ri_writeEnable     = 1'b1;
            ri_writeByteEnable = 4'hF;
            ri_writeAddress    = {index_q, rsp_off};
            ri_writeData       = mem.readData;
        end

        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = start_dirty ? WB_RD : RF_REQ;
            end
            WB_RD: begin
                ri_readAddress = {index_q, wb_cnt};
                state_nx       = WB_WR;
            end
            WB_WR: begin
                ri_readAddress = {index_q, wb_cnt};
                mem.write      = 1'b1;
                mem.writeData  = ri_readData;
                mem.address    = wb_addr_q +
                                 {{(30-LW){1'b0}}, wb_cnt, 2'b00};
                if (wb_acc)
                    state_nx = (&wb_cnt) ? RF_REQ : WB_RD;
            end
            RF_REQ: begin
                mem.read    = 1'b1;
                mem.address = rf_base_q +
                              {{(30-LW){1'b0}}, req_off, 2'b00};
                if (rsp_fire && (&rsp_cnt))
                    state_nx = DONE;
                else if (rf_acc && (&req_cnt))
                    state_nx = RF_WAIT;
            end
            RF_WAIT: begin
                if (rsp_fire && (&rsp_cnt))
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_replace_data.sv
// Randomized bench for cache_replace_data against a line-level model.
// Honors CACHE_REPLACE_CRITICAL_WORD_FIRST_EN the same way as the design.
module tb_cache_replace_data;
    localparam int AW = 8;
    localparam int LW = 2;
    localparam int NW = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_dirty = 1'b0;
    logic [1:0]  start_ch = '0;
    logic [5:0]  start_index = '0;
    logic [31:0] start_wbAddr = '0;
    logic [31:0] start_refillAddr = '0;
    logic        busy, done, sel;
    logic [7:0]  ri_readAddress, ri_writeAddress;
    logic [1:0]  ri_rwChannel;
    logic [31:0] ri_readData;
    logic [3:0]  ri_writeByteEnable;
    logic        ri_writeEnable;
    logic [31:0] ri_writeData;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ram     [4][256];
    logic [31:0] ref_arr [4][256];

    pair_t       exp_wr[$];
    pair_t       exp_aw[$];
    logic [31:0] exp_rd[$];
    logic [31:0] pend[$];

    cache_replace_data_if mem_bus();

    cache_replace_data #(
        .ADDR_WIDTH(AW),
        .LINE_WORDS_LOG2(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_dirty(start_dirty),
        .start_ch(start_ch),
        .start_index(start_index),
        .start_wbAddr(start_wbAddr),
        .start_refillAddr(start_refillAddr),
        .busy(busy),
        .done(done),
        .sel(sel),
        .ri_readAddress(ri_readAddress),
        .ri_rwChannel(ri_rwChannel),
        .ri_readData(ri_readData),
        .ri_writeAddress(ri_writeAddress),
        .ri_writeByteEnable(ri_writeByteEnable),
        .ri_writeEnable(ri_writeEnable),
        .ri_writeData(ri_writeData),
        .mem(mem_bus),
        .fwd_valid(fwd_valid),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read data array seen by the engine.
    always @(posedge clk)
        ri_readData <= ram[ri_rwChannel][ri_readAddress];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input bit dirty, input logic [1:0] ch,
                           input logic [5:0] idx, input logic [31:0] wba,
                           input logic [31:0] rfa, input int stall_pct,
                           input bit wb_stall, input bit poke,
                           input bit abort);
        int          crit;
        int          aw_n;
        int          wr_n;
        int          stall_left;
        bit          done_next;
        bit          finished;
        bit          poked;
        logic [31:0] base;
        pair_t       p;

        exp_wr.delete();
        exp_aw.delete();
        exp_rd.delete();
        pend.delete();
`ifdef CACHE_REPLACE_CRITICAL_WORD_FIRST_EN
        crit = int'(rfa[3:2]);
`else
        crit = 0;
`endif
        base = rfa & ~32'hF;
        if (dirty)
            for (int i = 0; i < NW; i++) begin
                p.a = wba + 32'(4 * i);
                p.d = ref_arr[ch][int'(idx) * NW + i];
                exp_wr.push_back(p);
            end
        for (int i = 0; i < NW; i++) begin
            int w;
            w = (crit + i) % NW;
            exp_rd.push_back(base + 32'(4 * w));
            p.a = 32'(int'(idx) * NW + w);
            p.d = mem_word(base + 32'(4 * w));
            exp_aw.push_back(p);
        end

        @(negedge clk);
        start = 1'b1;
        start_dirty = dirty;
        start_ch = ch;
        start_index = idx;
        start_wbAddr = wba;
        start_refillAddr = rfa;
        mem_bus.waitRequest = 1'b0;
        mem_bus.readDataValid = 1'b0;
        #1;
        check("idle_busy", busy, 0);

        aw_n = 0;
        wr_n = 0;
        done_next = 0;
        finished = 0;
        poked = 0;
        stall_left = wb_stall ? 3 : 0;

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            start_dirty = 1'($urandom);
            start_ch = 2'($urandom);
            start_index = 6'($urandom);
            start_wbAddr = $urandom;
            start_refillAddr = $urandom;
            if (poke && !poked && mem_bus.write) begin
                start = 1'b1;
                poked = 1;
            end

            if (abort && aw_n == 2) begin
                mem_bus.readDataValid = 1'b1;
                mem_bus.readData = $urandom;
                rst_n = 1'b0;
                #1;
                check("rst_sel", sel, 0);
                check("rst_busy", busy, 0);
                check("rst_read", mem_bus.read, 0);
                check("rst_we", ri_writeEnable, 0);
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("rst_we_hold", ri_writeEnable, 0);
                end
                mem_bus.readDataValid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            if (wb_stall && mem_bus.write && wr_n == 1 && stall_left > 0) begin
                mem_bus.waitRequest = 1'b1;
                stall_left--;
            end else begin
                mem_bus.waitRequest = ($urandom_range(99) < stall_pct);
            end
            if (pend.size() > 0 && $urandom_range(99) >= stall_pct) begin
                mem_bus.readDataValid = 1'b1;
                mem_bus.readData = pend.pop_front();
            end else begin
                mem_bus.readDataValid = 1'b0;
                mem_bus.readData = $urandom;
            end
            #1;

            check("busy", busy, 1);
            check("sel", sel, 1);
            check("chan", ri_rwChannel, ch);
            check("done", done, done_next);
            check("rw_excl", mem_bus.read & mem_bus.write, 0);
            if (done)
                finished = 1;
            done_next = 0;

            if (mem_bus.write) begin
                if (exp_wr.size() == 0) begin
                    check("wb_extra", 1, 0);
                end else begin
                    check("wb_addr", mem_bus.address, exp_wr[0].a);
                    check("wb_data", mem_bus.writeData, exp_wr[0].d);
                    if (!mem_bus.waitRequest) begin
                        void'(exp_wr.pop_front());
                        wr_n++;
                    end
                end
            end

            if (mem_bus.read) begin
                check("rf_after_wb", exp_wr.size(), 0);
                if (exp_rd.size() == 0) begin
                    check("rd_extra", 1, 0);
                end else begin
                    check("rd_addr", mem_bus.address, exp_rd[0]);
                    if (!mem_bus.waitRequest)
                        pend.push_back(mem_word(exp_rd.pop_front()));
                end
            end

            check("ri_we", ri_writeEnable, mem_bus.readDataValid);
`ifdef CACHE_REPLACE_CRITICAL_WORD_FIRST_EN
            check("fwd_valid", fwd_valid,
                  mem_bus.readDataValid && aw_n == 0);
            if (mem_bus.readDataValid && aw_n == 0)
                check("fwd_data", fwd_data, exp_aw[0].d);
`else
            check("fwd_valid", fwd_valid, 0);
            check("fwd_data", fwd_data, 0);
`endif
            if (mem_bus.readDataValid) begin
                p = exp_aw.pop_front();
                check("ri_waddr", ri_writeAddress, p.a);
                check("ri_wdata", ri_writeData, p.d);
                check("ri_be", ri_writeByteEnable, 4'hF);
                ref_arr[ch][p.a] = p.d;
                aw_n++;
                if (aw_n == NW)
                    done_next = 1;
            end
            if (ri_writeEnable)
                ram[ri_rwChannel][ri_writeAddress] = ri_writeData;
        end

        if (!finished) begin
            check("timeout", 1, 0);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end

        @(negedge clk);
        start = 1'b0;
        mem_bus.readDataValid = 1'b0;
        mem_bus.waitRequest = 1'b0;
        #1;
        check("post_busy", busy, 0);
        check("post_sel", sel, 0);
        check("post_done", done, 0);
        check("wr_left", exp_wr.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        check("aw_left", exp_aw.size(), 0);
    endtask

    initial begin
        mem_bus.waitRequest = 1'b0;
        mem_bus.readDataValid = 1'b0;
        mem_bus.readData = '0;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++) begin
                ram[c][a] = $urandom;
                ref_arr[c][a] = ram[c][a];
            end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy0", busy, 0);
        check("rst_sel0", sel, 0);
        check("rst_done0", done, 0);
        check("rst_mread0", mem_bus.read, 0);
        check("rst_mwrite0", mem_bus.write, 0);
        check("rst_maddr0", mem_bus.address, 0);
        check("rst_mwdata0", mem_bus.writeData, 0);
        check("rst_we0", ri_writeEnable, 0);
        check("rst_raddr0", ri_readAddress, 0);
        check("rst_waddr0", ri_writeAddress, 0);
        check("rst_chan0", ri_rwChannel, 0);
        check("rst_fwd0", fwd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, 2'd2, 6'd5, 32'h0, 32'h1000, 0, 0, 0, 0);

        for (int i = 0; i < NW; i++) begin
            ram[1][7 * NW + i] = 32'hA0 + 32'(i);
            ref_arr[1][7 * NW + i] = 32'hA0 + 32'(i);
        end
        run_txn(1, 2'd1, 6'd7, 32'h2000, 32'h4040, 0, 1, 0, 0);

        run_txn(0, 2'd3, 6'd9, 32'h0, 32'h5000, 0, 0, 0, 1);
        run_txn(0, 2'd3, 6'd9, 32'h0, 32'h5000, 20, 0, 0, 0);

        run_txn(1, 2'd0, 6'd12, 32'h6000, 32'h7010, 30, 0, 1, 0);

        run_txn(0, 2'd1, 6'd3, 32'h0, 32'h3008, 0, 0, 0, 0);

        repeat (40) begin
            logic [31:0] wba;
            wba = $urandom & ~32'hF;
            run_txn(1'($urandom), 2'($urandom), 6'($urandom), wba,
                    $urandom, int'($urandom_range(0, 60)), 0,
                    1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
